// File: rtl/time_base_ctrl.sv
// time_base_ctrl: controller for the TIC/accumulator time base.
// Stages CPU-written divider values and commits them only on period
// boundaries. It also counts TICs and manages the accumulator interrupt
// flag with ack/overrun tracking. Optional feature macro: TIC_SLEW_EN
// (IDLE/ARMED/SLEWING FSM that stretches or shrinks one TIC period).
// Handshake note: every strobe input (wr_en, accum_ack, *_enable) is a
// single-cycle pulse sampled at the rising edge; there is no back-pressure.
module time_base_ctrl #(
  parameter logic [23:0] DEF_TIC_DIVIDE   = 24'h18F9BF,
  parameter logic [23:0] DEF_ACCUM_DIVIDE = 24'h00398A,
  parameter int          IDX_W            = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [23:0]      wr_data,
  input  logic             pre_tic_enable,
  input  logic             tic_enable,
  input  logic             accum_enable,
  input  logic             accum_ack,
  output logic [23:0]      tic_divide,
  output logic [23:0]      accum_divide,
  output logic [IDX_W-1:0] tic_index,
  output logic             accum_int,
  output logic             accum_overrun,
  output logic             tic_pend,
  output logic             accum_pend,
  output logic             slew_busy
);

  // Register decode.
  logic wr_tic, wr_accum, wr_ctrl;
  logic clr_idx, clr_ovr;
  logic [23:0] tic_stage;
  logic [23:0] accum_stage;

  assign wr_tic   = wr_en && (wr_addr == 2'd0);
  assign wr_accum = wr_en && (wr_addr == 2'd1);
  assign wr_ctrl  = wr_en && (wr_addr == 2'd3);
  assign clr_idx  = wr_ctrl && wr_data[0];
  assign clr_ovr  = wr_ctrl && wr_data[1];

`ifdef TIC_SLEW_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SLEWING = 2'd2
  } slew_state_e;

  slew_state_e state_q, state_d;
  logic [23:0] slew_val;
  logic [23:0] tic_nom;
  logic        wr_slew;
  logic        abort;

  assign wr_slew   = wr_en && (wr_addr == 2'd2);
  assign abort     = wr_ctrl && wr_data[2];
  assign slew_busy = (state_q != IDLE);

  // Slew FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Slew FSM next state: arm on a slew write, apply for exactly one TIC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_slew) state_d = ARMED;
      ARMED: begin
        if (tic_enable) state_d = SLEWING;
        else if (abort) state_d = IDLE;
      end
      SLEWING: if (tic_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slew value is captured only when a new slew is being armed.
  always_ff @(posedge clk) begin
    if (!rstn)                            slew_val <= '0;
    else if ((state_q == IDLE) && wr_slew) slew_val <= wr_data;
  end

  // TIC divider path: commits at TIC boundaries, slew overrides one period.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tic_divide <= DEF_TIC_DIVIDE;
      tic_nom    <= DEF_TIC_DIVIDE;
      tic_stage  <= DEF_TIC_DIVIDE;
      tic_pend   <= 1'b0;
    end else begin
      if (tic_enable) begin
        case (state_q)
          IDLE: begin
            if (tic_pend) begin
              tic_nom    <= tic_stage;
              tic_divide <= tic_stage;
              tic_pend   <= 1'b0;
            end
          end
          ARMED: tic_divide <= slew_val;
          SLEWING: begin
            if (tic_pend) begin
              tic_nom    <= tic_stage;
              tic_divide <= tic_stage;
              tic_pend   <= 1'b0;
            end else begin
              tic_divide <= tic_nom;
            end
          end
          default: ;
        endcase
      end
      // A write in the commit cycle re-stages after the old stage is used.
      if (wr_tic) begin
        tic_stage <= wr_data;
        tic_pend  <= 1'b1;
      end
    end
  end
`else
  assign slew_busy = 1'b0;

  // TIC divider path: staged value commits at the next TIC boundary.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tic_divide <= DEF_TIC_DIVIDE;
      tic_stage  <= DEF_TIC_DIVIDE;
      tic_pend   <= 1'b0;
    end else begin
      if (tic_enable && tic_pend) begin
        tic_divide <= tic_stage;
        tic_pend   <= 1'b0;
      end
      // A write in the commit cycle re-stages after the old stage is used.
      if (wr_tic) begin
        tic_stage <= wr_data;
        tic_pend  <= 1'b1;
      end
    end
  end
`endif

  // Accum divider path: staged value commits at the next accum boundary.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      accum_divide <= DEF_ACCUM_DIVIDE;
      accum_stage  <= DEF_ACCUM_DIVIDE;
      accum_pend   <= 1'b0;
    end else begin
      if (accum_enable && accum_pend) begin
        accum_divide <= accum_stage;
        accum_pend   <= 1'b0;
      end
      if (wr_accum) begin
        accum_stage <= wr_data;
        accum_pend  <= 1'b1;
      end
    end
  end

  // TIC counter: clear wins over a simultaneous increment; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rstn)           tic_index <= '0;
    else if (clr_idx)    tic_index <= '0;
    else if (tic_enable) tic_index <= tic_index + IDX_W'(1);
  end

  // Accumulator interrupt flag with sticky overrun; set beats clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      accum_int     <= 1'b0;
      accum_overrun <= 1'b0;
    end else begin
      if (accum_enable)   accum_int <= 1'b1;
      else if (accum_ack) accum_int <= 1'b0;

      if (accum_enable && accum_int && !accum_ack) accum_overrun <= 1'b1;
      else if (clr_ovr)                            accum_overrun <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // time_base contract: tic_enable is pre_tic_enable delayed by one clock.
  tic_follows_pre: assert property (@(posedge clk) disable iff (!rstn)
    tic_enable == $past(pre_tic_enable));
`endif

endmodule

// File: tb/tb_time_base_ctrl.sv
// Bench for time_base_ctrl. A small time_base emulator generates the
// enable pulses from the DUT's own divide outputs; a behavioural model
// predicts every output and is compared each cycle on the falling edge.
// Build with TIC_SLEW_EN defined to exercise the slew feature.
module tb_time_base_ctrl;

`ifdef TIC_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif
  localparam logic [23:0] DEF_TIC   = 24'h18F9BF;
  localparam logic [23:0] DEF_ACCUM = 24'h00398A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [23:0] wr_data = 24'd0;
  logic        pre_tic_enable = 1'b0;
  logic        tic_enable = 1'b0;
  logic        accum_enable = 1'b0;
  logic        accum_ack = 1'b0;

  logic [23:0] tic_divide, accum_divide;
  logic [31:0] tic_index;
  logic        accum_int, accum_overrun, tic_pend, accum_pend, slew_busy;

  logic [23:0] s_tic_divide, s_accum_divide;
  logic [2:0]  s_tic_index;
  logic        s_accum_int, s_accum_overrun, s_tic_pend, s_accum_pend, s_slew_busy;

  time_base_ctrl dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pre_tic_enable(pre_tic_enable), .tic_enable(tic_enable),
    .accum_enable(accum_enable), .accum_ack(accum_ack),
    .tic_divide(tic_divide), .accum_divide(accum_divide), .tic_index(tic_index),
    .accum_int(accum_int), .accum_overrun(accum_overrun), .tic_pend(tic_pend),
    .accum_pend(accum_pend), .slew_busy(slew_busy)
  );

  // Narrow-index copy so the index wrap is reachable in a short run.
  time_base_ctrl #(.IDX_W(3)) dut_small (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pre_tic_enable(pre_tic_enable), .tic_enable(tic_enable),
    .accum_enable(accum_enable), .accum_ack(accum_ack),
    .tic_divide(s_tic_divide), .accum_divide(s_accum_divide), .tic_index(s_tic_index),
    .accum_int(s_accum_int), .accum_overrun(s_accum_overrun), .tic_pend(s_tic_pend),
    .accum_pend(s_accum_pend), .slew_busy(s_slew_busy)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  logic [23:0] m_tdiv, m_nom, m_tstage, m_adiv, m_astage, m_slew;
  logic [31:0] m_cnt;
  bit          m_tpend, m_apend, m_int, m_ovr;
  int          m_mode;   // 0 idle, 1 armed, 2 slewing

  always @(posedge clk) begin
    bit w_tic, w_acc, w_slew, w_ctrl, set_ovr;
    int old_mode;
    if (!rstn) begin
      m_valid = 1'b1;
      m_tdiv = DEF_TIC; m_nom = DEF_TIC; m_adiv = DEF_ACCUM;
      m_cnt = 0; m_tpend = 0; m_apend = 0; m_int = 0; m_ovr = 0; m_mode = 0;
    end else begin
      w_tic  = wr_en && wr_addr == 2'd0;
      w_acc  = wr_en && wr_addr == 2'd1;
      w_slew = wr_en && wr_addr == 2'd2;
      w_ctrl = wr_en && wr_addr == 2'd3;
      old_mode = m_mode;
      if (tic_enable) begin
        if (old_mode == 1) m_tdiv = m_slew;
        else begin
          if (m_tpend) begin m_nom = m_tstage; m_tpend = 0; end
          if (old_mode == 2 || m_tdiv != m_nom) m_tdiv = m_nom;
        end
      end
      if (SLEW) begin
        if (old_mode == 0 && w_slew) begin m_slew = wr_data; m_mode = 1; end
        else if (old_mode == 1 && tic_enable) m_mode = 2;
        else if (old_mode == 1 && w_ctrl && wr_data[2]) m_mode = 0;
        else if (old_mode == 2 && tic_enable) m_mode = 0;
      end
      if (w_tic) begin m_tstage = wr_data; m_tpend = 1; end
      if (accum_enable && m_apend) begin m_adiv = m_astage; m_apend = 0; end
      if (w_acc) begin m_astage = wr_data; m_apend = 1; end
      if (w_ctrl && wr_data[0]) m_cnt = 0;
      else if (tic_enable) m_cnt = m_cnt + 1;
      set_ovr = accum_enable && m_int && !accum_ack;
      if (accum_enable) m_int = 1;
      else if (accum_ack) m_int = 0;
      if (set_ovr) m_ovr = 1;
      else if (w_ctrl && wr_data[1]) m_ovr = 0;
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("tic_divide", tic_divide, m_tdiv);
      check("accum_divide", accum_divide, m_adiv);
      check("tic_index", tic_index, m_cnt);
      check("tic_index_w3", s_tic_index, m_cnt % 8);
      check("accum_int", accum_int, m_int);
      check("accum_overrun", accum_overrun, m_ovr);
      check("tic_pend", tic_pend, m_tpend);
      check("accum_pend", accum_pend, m_apend);
      check("slew_busy", slew_busy, m_mode != 0);
      check("small_flags", {s_tic_divide, s_accum_divide, s_accum_int, s_accum_overrun,
                            s_tic_pend, s_accum_pend, s_slew_busy},
                           {tic_divide, accum_divide, accum_int, accum_overrun,
                            tic_pend, accum_pend, slew_busy});
    end
  end

  // ---------------- driver / time_base emulator ----------------
  bit   auto_tic = 0, auto_acc = 0, man_pre = 0, man_acc = 0;
  int   tic_cnt = 0, acc_cnt = 0, cyc = 0, last_tic = 0, last_acc = 0;
  int   tic_ivl_q[$];
  int   acc_ivl_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 0; wr_addr = 0; wr_data = 0; accum_ack = 0;
    cyc++;
    tic_enable = pre_tic_enable;
    if (tic_enable) begin tic_ivl_q.push_back(cyc - last_tic); last_tic = cyc; end
    if (auto_tic) begin
      if (tic_cnt == 0) begin pre_tic_enable = 1; tic_cnt = int'(tic_divide); end
      else begin pre_tic_enable = 0; tic_cnt--; end
    end else begin
      pre_tic_enable = man_pre; man_pre = 0;
    end
    if (auto_acc) begin
      if (acc_cnt == 0) begin accum_enable = 1; acc_cnt = int'(accum_divide); end
      else begin accum_enable = 0; acc_cnt--; end
      if (accum_enable) begin acc_ivl_q.push_back(cyc - last_acc); last_acc = cyc; end
    end else begin
      accum_enable = man_acc; man_acc = 0;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  // Leaves tic_enable asserted for the next edge.
  task automatic tic_arm();
    man_pre = 1; tick(); tick();
  endtask

  // Leaves accum_enable asserted for the next edge.
  task automatic acc_arm();
    man_acc = 1; tick();
  endtask

  task automatic wait_tics(input int n, input string name);
    for (int i = 0; i < 600 && tic_ivl_q.size() < n; i++) tick();
    check({name, "_timeout"}, tic_ivl_q.size() >= n, 1);
  endtask

  // Park just after a TIC boundary, four cycles into a period.
  task automatic sync_mid(input string name);
    int k;
    k = 0;
    while (!tic_enable && k < 600) begin tick(); k++; end
    check({name, "_sync"}, tic_enable, 1);
    repeat (5) tick();
  endtask

  task automatic check_ivls(input string name, input int exp[]);
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_period%0d", name, i),
            (i < tic_ivl_q.size()) ? tic_ivl_q[i] : -1, exp[i]);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) tick();
    check("rst_tic_divide", tic_divide, 24'h18F9BF);
    check("rst_accum_divide", accum_divide, 24'h00398A);
    check("rst_index", tic_index, 0);
    check("rst_flags", {accum_int, accum_overrun, tic_pend, accum_pend, slew_busy}, 0);
    rstn = 1;
    tick();

    // Stage 9 and commit it with a single boundary.
    wr(0, 24'd9); tick();
    check("stage_pend", tic_pend, 1);
    tic_arm(); tick();
    check("commit9", tic_divide, 24'd9);
    check("commit9_pend", tic_pend, 0);

    // Mid-period write of 4: one more 10-clk period, then 5-clk periods.
    auto_tic = 1; tic_cnt = 0;
    tic_ivl_q.delete(); wait_tics(2, "warm");
    sync_mid("t4");
    tic_ivl_q.delete();
    wr(0, 24'd4); tick();
    check("t4_pend", tic_pend, 1);
    check("t4_div_hold", tic_divide, 24'd9);
    wait_tics(1, "t4_commit"); tick();
    check("t4_div", tic_divide, 24'd4);
    check("t4_pend_clr", tic_pend, 0);
    wait_tics(4, "t4_run");
    check_ivls("t4", '{10, 10, 5, 5});

    // TIC write landing on the commit edge: old stage used, new one pending.
    wr(0, 24'd6); tick();
    sync_mid("tc");
    while (!tic_enable && cyc < 90000) tick();
    wr(0, 24'd8); tick();
    check("tc_div", tic_divide, 24'd6);
    check("tc_pend", tic_pend, 1);
    while (!tic_enable && cyc < 90000) tick();
    tick();
    check("tc_div2", tic_divide, 24'd8);

    // Index clear versus increment, and the 3-bit wrap.
    auto_tic = 0; repeat (12) tick();
    tic_arm(); wr(3, 24'd1); tick();
    check("idx_clr_vs_inc", tic_index, 0);
    for (int i = 0; i < 9; i++) begin tic_arm(); tick(); end
    check("idx_9", tic_index, 9);
    check("idx_w3_wrap", s_tic_index, 1);

    // Accum commit, interrupt, overrun, ack.
    wr(1, 24'd3); tick();
    acc_arm(); tick();
    check("acc_div3", accum_divide, 24'd3);
    check("acc_int_set", accum_int, 1);
    acc_arm(); tick();
    check("acc_overrun", accum_overrun, 1);
    wr(3, 24'd2); tick();
    check("acc_ovr_clr", accum_overrun, 0);
    acc_arm(); accum_ack = 1; tick();
    check("ack_coinc_int", accum_int, 1);
    check("ack_coinc_ovr", accum_overrun, 0);
    accum_ack = 1; tick();
    check("ack_clears", accum_int, 0);
    acc_arm(); tick();
    acc_arm(); wr(3, 24'd2); tick();
    check("ovr_set_beats_clr", accum_overrun, 1);
    wr(1, 24'd7); tick();
    acc_arm(); wr(1, 24'd2); tick();
    check("acc_coinc_div", accum_divide, 24'd7);
    check("acc_coinc_pend", accum_pend, 1);
    acc_arm(); tick();
    check("acc_div2", accum_divide, 24'd2);
    auto_acc = 1; acc_cnt = 0; acc_ivl_q.delete();
    repeat (14) tick();
    for (int i = 1; i < 4; i++)
      check($sformatf("acc_period%0d", i), (i < acc_ivl_q.size()) ? acc_ivl_q[i] : -1, 3);
    auto_acc = 0; accum_ack = 1; tick();

`ifdef TIC_SLEW_EN
    // Back to a 10-clk period, then one 3-clk slewed period.
    wr(0, 24'd9); tic_arm(); tick();
    check("slew_base", tic_divide, 24'd9);
    auto_tic = 1; tic_cnt = 0;
    sync_mid("s1");
    tic_ivl_q.delete();
    wr(2, 24'd2); tick();
    check("slew_armed", slew_busy, 1);
    wait_tics(4, "s1_run");
    check_ivls("s1", '{10, 10, 3, 10});
    check("slew_done", slew_busy, 0);

    // Stage 6 while slewing: after the slew, 7-clk periods.
    sync_mid("s2");
    tic_ivl_q.delete();
    wr(2, 24'd2); tick();
    wait_tics(1, "s2_arm"); tick();
    wr(0, 24'd6); tick();
    check("s2_pend", tic_pend, 1);
    check("s2_busy", slew_busy, 1);
    wait_tics(5, "s2_run");
    check_ivls("s2", '{10, 10, 3, 7, 7});

    // Abort while armed.
    auto_tic = 0; repeat (12) tick();
    wr(2, 24'd5); tick();
    check("abort_armed", slew_busy, 1);
    wr(3, 24'd4); tick();
    check("abort_idle", slew_busy, 0);
    tic_arm(); tick();
    check("abort_div", tic_divide, 24'd6);
`else
    wr(2, 24'd5); tick();
    check("no_slew_busy", slew_busy, 0);
    wr(3, 24'd4); tic_arm(); tick();
    check("no_slew_div", tic_divide, 24'd8);
`endif

    // Reset with a pending write discards it.
    wr(0, 24'd3); tick();
    rstn = 0; tick();
    check("rst2_pend", tic_pend, 0);
    check("rst2_div", tic_divide, 24'h18F9BF);
    rstn = 1; tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
